// File: rtl/sprite_sram_arbiter_if.sv
// Requester/SRAM-side bundle for sprite_sram_arbiter. The master side is the VGA top
// (AGUs plus SRAM read data); the slave side is the arbiter.
interface sprite_sram_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 12
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic                    sram_en;
  logic [ADDR_W-1:0]       sram_addr;
  logic [DATA_W-1:0]       sram_data;
  logic [N_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]       rd_data;

  modport master (
    output req, req_lock, req_addr, sram_data,
    input  gnt, sram_en, sram_addr, rd_valid, rd_data
  );

  modport slave (
    input  req, req_lock, req_addr, sram_data,
    output gnt, sram_en, sram_addr, rd_valid, rd_data
  );
endinterface

// File: rtl/sprite_sram_arbiter.sv
// Round-robin SRAM read-port arbiter with bounded burst lock and read-latency tag pipeline.
// Optional macro ARB_PRIO0_EN: requester 0 (background AGU) gets strict priority.
module sprite_sram_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 12,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sprite_sram_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic             owner_vld;
  logic [CNT_W-1:0] burst_cnt;

  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic             lock_hold;
  logic             claim;
  logic             ptr_upd;
  logic [PTR_W-1:0] next_ptr;
  logic [N_REQ-1:0] gnt_vec;
  logic [N_REQ-1:0] tag [RD_LAT];

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    int idx;
    int base;
    idx       = 0;
    base      = 0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    lock_hold = owner_vld && bus.req[owner] && bus.req_lock[owner] && (burst_cnt < CNT_LAST);
`ifdef ARB_PRIO0_EN
    if (bus.req[0]) begin
      gnt_any   = 1'b1;
      lock_hold = 1'b0;
    end else if (lock_hold) begin
      gnt_any = 1'b1;
      gnt_idx = owner;
    end else begin
      // Round-robin restricted to 1..N_REQ-1; a pointer of 0 behaves like 1.
      base = (rr_ptr == '0) ? 1 : int'(rr_ptr);
      for (int k = 0; k < N_REQ - 1; k++) begin
        idx = base + k;
        if (idx >= N_REQ) idx = idx - (N_REQ - 1);
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    claim   = gnt_any && (gnt_idx != '0) && bus.req_lock[gnt_idx];
    ptr_upd = gnt_any && (gnt_idx != '0);
`else
    if (lock_hold) begin
      gnt_any = 1'b1;
      gnt_idx = owner;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    claim   = gnt_any && bus.req_lock[gnt_idx];
    ptr_upd = gnt_any;
`endif
    next_ptr = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
    gnt_vec  = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  assign bus.gnt       = gnt_vec;
  assign bus.sram_en   = |bus.req;
  assign bus.sram_addr = gnt_any ? bus.req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
  assign bus.rd_data   = DATA_W'(bus.sram_data);
  assign bus.rd_valid  = tag[RD_LAT-1];

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      burst_cnt <= '0;
    end else if (gnt_any) begin
      if (ptr_upd) rr_ptr <= next_ptr;
      if (lock_hold) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else if (claim) begin
        // Fresh lock, or a forced release re-won through round-robin: a new burst starts.
        owner     <= gnt_idx;
        owner_vld <= 1'b1;
        burst_cnt <= '0;
      end else begin
        owner     <= '0;
        owner_vld <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

  // NOTE: the tag shift register is explicitly reset so reads in flight at reset never report valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= gnt_vec;
      for (int i = 1; i < RD_LAT; i++) tag[i] <= tag[i-1];
    end
  end

endmodule

// File: tb/tb_sprite_sram_arbiter.sv
// Directed self-checking bench for sprite_sram_arbiter: one DUT with RD_LAT=1, one with RD_LAT=3.
module tb_sprite_sram_arbiter;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 12;
  localparam int MB = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sprite_sram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  sprite_sram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  sprite_sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(MB)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
  );
  sprite_sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_BURST(MB)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave)
  );

  // Model SRAM for the RD_LAT=1 instance: returns the low address bits one cycle later.
  always @(posedge clk) bus1.sram_data <= bus1.sram_addr[DW-1:0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.req      = '0;
    bus1.req_lock = '0;
    bus3.req      = '0;
    bus3.req_lock = '0;
  endtask

  task automatic set_addrs();
    for (int i = 0; i < N; i++) begin
      bus1.req_addr[i*AW +: AW] = AW'(i * 100);
      bus3.req_addr[i*AW +: AW] = AW'(i * 100);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (bus1.gnt !== '0) begin
        failures++;
        $display("FAIL reset_gnt c=%0d: got %b expected 0000", c, bus1.gnt);
      end
      checks++;
      if (bus1.sram_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_sram_en c=%0d: got %b expected 0", c, bus1.sram_en);
      end
      checks++;
      if (bus1.sram_addr !== '0) begin
        failures++;
        $display("FAIL reset_sram_addr c=%0d: got %0d expected 0", c, bus1.sram_addr);
      end
      checks++;
      if (bus1.rd_valid !== '0 || bus3.rd_valid !== '0) begin
        failures++;
        $display("FAIL reset_rd_valid c=%0d: got %b/%b expected 0000", c, bus1.rd_valid, bus3.rd_valid);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  exp_g;
    logic [N-1:0]  exp_v;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    do_reset();
    bus1.req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      exp_g = N'(1) << (c % 4);
      exp_a = AW'((c % 4) * 100);
      exp_v = (c == 0) ? '0 : N'(1) << ((c - 1) % 4);
      exp_d = (c == 0) ? '0 : DW'(((c - 1) % 4) * 100);
      #1;
      checks++;
      if (bus1.gnt !== exp_g) begin
        failures++;
        $display("FAIL rr_gnt c=%0d: got %b expected %b", c, bus1.gnt, exp_g);
      end
      checks++;
      if (bus1.sram_addr !== exp_a || bus1.sram_en !== 1'b1) begin
        failures++;
        $display("FAIL rr_addr c=%0d: got %0d/%b expected %0d/1", c, bus1.sram_addr, bus1.sram_en, exp_a);
      end
      checks++;
      if (bus1.rd_valid !== exp_v) begin
        failures++;
        $display("FAIL rr_rd_valid c=%0d: got %b expected %b", c, bus1.rd_valid, exp_v);
      end
      if (c > 0) begin
        checks++;
        if (bus1.rd_data !== exp_d) begin
          failures++;
          $display("FAIL rr_rd_data c=%0d: got %h expected %h", c, bus1.rd_data, exp_d);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_burst();
    logic [N-1:0] exp_g;
    do_reset();
    bus1.req = 4'b0010;
    #1;
    checks++;
    if (bus1.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL burst_setup: got %b expected 0010", bus1.gnt);
    end
    step();
    bus1.req      = 4'b1111;
    bus1.req_lock = 4'b0100;
    for (int c = 0; c < 18; c++) begin
      exp_g = (c < 16) ? 4'b0100 : (c == 16) ? 4'b1000 : 4'b0001;
      #1;
      checks++;
      if (bus1.gnt !== exp_g) begin
        failures++;
        $display("FAIL burst_gnt c=%0d: got %b expected %b", c, bus1.gnt, exp_g);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_lock_drop();
    do_reset();
    bus1.req = 4'b0010;
    step();
    bus1.req      = 4'b1111;
    bus1.req_lock = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus1.gnt !== 4'b0100) begin
        failures++;
        $display("FAIL lockdrop_hold c=%0d: got %b expected 0100", c, bus1.gnt);
      end
      step();
    end
    bus1.req = 4'b1011;
    #1;
    checks++;
    if (bus1.gnt !== 4'b1000) begin
      failures++;
      $display("FAIL lockdrop_ignore: got %b expected 1000", bus1.gnt);
    end
    step();
    bus1.req = 4'b0111;
    #1;
    checks++;
    if (bus1.gnt !== 4'b0001) begin
      failures++;
      $display("FAIL lockdrop_wrap: got %b expected 0001", bus1.gnt);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_latency();
    logic [N-1:0] exp_v;
    do_reset();
    bus3.sram_data = 12'h5A5;
    for (int c = 0; c < 13; c++) begin
      bus3.req = (c == 5) ? 4'b0010 : 4'b0000;
      exp_v    = (c == 8) ? 4'b0010 : 4'b0000;
      #1;
      if (c == 5) begin
        checks++;
        if (bus3.gnt !== 4'b0010) begin
          failures++;
          $display("FAIL lat_gnt: got %b expected 0010", bus3.gnt);
        end
      end
      checks++;
      if (bus3.rd_valid !== exp_v) begin
        failures++;
        $display("FAIL lat_rd_valid c=%0d: got %b expected %b", c, bus3.rd_valid, exp_v);
      end
      if (c == 8) begin
        checks++;
        if (bus3.rd_data !== 12'h5A5) begin
          failures++;
          $display("FAIL lat_rd_data: got %h expected 5a5", bus3.rd_data);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      bus3.req = (c == 5) ? 4'b0001 : (c == 6) ? 4'b0100 : (c == 13) ? 4'b1010 : 4'b0000;
      reset_n  = (c == 7) ? 1'b0 : 1'b1;
      #1;
      if (c == 5) begin
        checks++;
        if (bus3.gnt !== 4'b0001) begin
          failures++;
          $display("FAIL flight_gnt5: got %b expected 0001", bus3.gnt);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus3.gnt !== 4'b0100) begin
          failures++;
          $display("FAIL flight_gnt6: got %b expected 0100", bus3.gnt);
        end
      end
      if (c >= 5 && c <= 12) begin
        checks++;
        if (bus3.rd_valid !== 4'b0000) begin
          failures++;
          $display("FAIL flight_rd_valid c=%0d: got %b expected 0000", c, bus3.rd_valid);
        end
      end
      if (c == 13) begin
        checks++;
        if (bus3.gnt !== 4'b0010) begin
          failures++;
          $display("FAIL flight_post_reset_gnt: got %b expected 0010", bus3.gnt);
        end
      end
      step();
    end
    reset_n = 1'b1;
    idle_inputs();
  endtask

`ifdef ARB_PRIO0_EN
  task automatic test_prio0();
    logic [N-1:0] exp_g;
    do_reset();
    bus1.req      = 4'b1000;
    bus1.req_lock = 4'b1000;
    #1;
    checks++;
    if (bus1.gnt !== 4'b1000) begin
      failures++;
      $display("FAIL prio_owner: got %b expected 1000", bus1.gnt);
    end
    step();
    bus1.req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus1.gnt !== 4'b0001) begin
        failures++;
        $display("FAIL prio_zero c=%0d: got %b expected 0001", c, bus1.gnt);
      end
      step();
    end
    bus1.req = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      exp_g = N'(2) << c;
      #1;
      checks++;
      if (bus1.gnt !== exp_g) begin
        failures++;
        $display("FAIL prio_resume c=%0d: got %b expected %b", c, bus1.gnt, exp_g);
      end
      step();
    end
    idle_inputs();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    idle_inputs();
    bus3.sram_data = '0;
    set_addrs();
    test_reset();
`ifdef ARB_PRIO0_EN
    test_prio0();
`else
    test_round_robin();
    test_burst();
    test_lock_drop();
`endif
    test_latency();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_sram_arbiter.md
Name: sprite_sram_arbiter

Overview:
Shares one read port of a sprite/background SRAM between up to N_REQ pixel-fetch requesters, such as the background AGU and several sprite AGUs. Sharing this way lets several sprites live in one BRAM instead of one dual-port RAM per pair of sprites. The block does round-robin arbitration with bounded burst locking and a tag pipeline matched to the SRAM read latency. It routes each returned word back to the requester that issued the read, and sits between the AGUs and the sram instance inside the VGA top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 18, SRAM address width
DATA_W, 12, pixel word width (RGB444)
RD_LAT, 1, SRAM read latency in clk cycles (1..4)
MAX_BURST, 16, maximum consecutive grants to one locked requester

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
req  in  N_REQ  per-requester read request; held until granted
req_lock  in  N_REQ  per-requester burst lock request; keeps the grant while req and req_lock are both high
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
gnt  out  N_REQ  one-hot grant (combinational, same cycle as req)
sram_en  out  1  SRAM enable, equal to |req
sram_addr  out  ADDR_W  address of the granted requester; 0 when idle
sram_data  in  DATA_W  SRAM read data
rd_valid  out  N_REQ  one-hot; rd_data belongs to requester i when bit i is high
rd_data  out  DATA_W  returned word, equal to sram_data passthrough

Behaviour:
- Reset (synchronous, sampled on the clk edge):
  - rr_ptr=0, owner=none, burst_cnt=0.
  - Tag pipeline cleared, so rd_valid=0 in the cycle after reset is applied.
  - gnt, sram_en and sram_addr are 0 whenever req=0.
- Arbitration, evaluated every cycle:
  - If owner is valid, req[owner]=1, req_lock[owner]=1 and burst_cnt<MAX_BURST-1: gnt=owner.
  - Otherwise gnt is the first i with req[i]=1, searching i=rr_ptr, rr_ptr+1, … mod N_REQ.
  - At most one gnt bit is ever set.
  - No req means gnt=0, sram_en=0 and no state change.
- Update on the edge that ends a cycle with grant g:
  - rr_ptr <= (g+1) mod N_REQ.
  - If req_lock[g]=1 and g==owner: burst_cnt <= burst_cnt+1.
  - Else if req_lock[g]=1: owner <= g, burst_cnt <= 0.
  - Else: owner <= none, burst_cnt <= 0.
- Forced release: once burst_cnt reaches MAX_BURST-1, the next arbitration ignores the lock and uses round-robin from rr_ptr. owner is cleared on that cycle.
  - If no other requester is active, the same requester may be granted again through round-robin, and a new burst starts if req_lock is still high.
- Requester contract: req_addr must be stable while req=1 and gnt[i]=0. Dropping req before the grant is legal and withdraws the request.
- Read-data return:
  - The grant vector enters a tag shift register of depth RD_LAT.
  - rd_valid in cycle T+RD_LAT equals gnt from cycle T, so throughput is one word per cycle.
  - rd_data = sram_data (no extra register).
- Boundaries:
  - rr_ptr wraps from N_REQ-1 to 0.
  - A lock held by a requester whose req has dropped is ignored.
  - Reset mid-burst or with reads in flight drops all pending tags, and no rd_valid is produced for them.
  - A requester at index ≥ N_REQ does not exist; no out-of-range indices are generated.

Optional Feature:
Macro ARB_PRIO0_EN.
- Defined: requester 0 (the background AGU) has strict priority.
  - If req[0]=1 it is granted, overriding locks and round-robin; any other owner's burst is terminated (owner cleared).
  - rr_ptr is updated only on grants to requesters 1..N_REQ-1, and round-robin runs among 1..N_REQ-1.
- Undefined: all requesters are equal, as described under Behaviour.

Test Plan:
- Reset then idle (req=0): gnt=0, sram_en=0, sram_addr=0, rd_valid=0 for 10 cycles.
- Round-robin: req=4'b1111, no locks, RD_LAT=1, addr[i]=i*100 → gnt sequence 0001,0010,0100,1000,0001…; rd_valid follows gnt one cycle later; a model SRAM returns data=addr[11:0] and rd_data matches.
- Burst lock: req=1111, req_lock[2]=1, MAX_BURST=16, rr_ptr=2 → 16 consecutive grants to 2, then gnt=1000 (requester 3), then 0001.
- Latency: RD_LAT=3, single req[1] pulse granted in cycle 5 → rd_valid=0010 exactly in cycle 8 and in no other cycle.
- Reset mid-flight: RD_LAT=3, grants in cycles 5 and 6, reset_n=0 sampled in cycle 7 → rd_valid stays 0 through cycle 12; first grant after release goes to the lowest requesting index starting from 0.
- ARB_PRIO0_EN: req=1111 with req_lock[3]=1 owning → gnt=0001 every cycle while req[0]=1; on req[0] dropping, grants resume 1,2,3 round-robin with owner cleared.
